draw_sprite: RTL
================

Name: draw_sprite

Overview:
- Parametrised sprite overlay stage in the VGA pixel pipeline, successor to the fixed-position single-image player drawer.
- Draws a SPRITE_W x SPRITE_H image from an external synchronous ROM at a run-time position, with these run-time features:
  - horizontal mirroring
  - colour-key transparency
  - multi-frame animation
- Position, mirror and visibility are latched once per frame so the sprite never tears.
- Sits between the background drawer and later overlay stages; passes all timing through with a fixed 2-cycle latency.

Parameters:
- SPRITE_W, 64, sprite width in pixels; power of two.
- SPRITE_H, 64, sprite height in pixels; power of two.
- AX_BITS, 6, log2(SPRITE_W).
- AY_BITS, 6, log2(SPRITE_H).
- FRAMES, 4, number of animation frames stored in ROM; power of two.
- FR_BITS, 2, log2(FRAMES).
- ANIM_DIV, 8, video frames per animation step; 1..255.
- KEY_COLOR, 12'h0F0, ROM colour treated as transparent.

Ports:
- clk60MHz  in  1  pixel clock.
- rst  in  1  asynchronous reset, active-high.
- xpos  in  11  requested sprite left edge, in hcount units.
- ypos  in  11  requested sprite top edge, in vcount units.
- mirror  in  1  1 = flip the image horizontally.
- visible  in  1  1 = draw the sprite.
- anim_en  in  1  1 = advance animation frames.
- rgb_pixel  in  12  ROM data; valid 1 cycle after pixel_addr.
- pixel_addr  out  FR_BITS+AY_BITS+AX_BITS  ROM address, ordered {frame, row, col}.
- in  vga_if.in  -  upstream timing plus rgb (vcount/hcount 11, syncs/blanks 1, rgb 12).
- out  vga_if.out  -  downstream timing plus rgb.

Behaviour:
- Reset (asynchronous, on rst high): all of the following are 0 while rst is high and until the first clock after release:
  - all out.* fields
  - the pipeline registers
  - the shadow registers (x_sh, y_sh, mirror_sh, visible_sh)
  - frame index and animation divider
  - A reset mid-frame therefore hides the sprite until the next frame latch.
- Frame latch:
  - vblnk_d registers in.vblnk.
  - On the cycle where in.vblnk=1 and vblnk_d=0, load x_sh<=xpos, y_sh<=ypos, mirror_sh<=mirror, visible_sh<=visible.
  - Input changes at any other time have no effect until the next latch.
- Animation:
  - The divider is evaluated on the same vblnk rising edge.
  - If anim_en=1: divider increments; at ANIM_DIV-1 it wraps to 0 and frame increments modulo FRAMES (FRAMES-1 -> 0).
  - If anim_en=0: divider and frame hold.
- Address (combinational from in.* and the shadow registers):
  - rel_x = in.hcount - x_sh, rel_y = in.vcount - y_sh, both 11-bit wrapping.
  - col = mirror_sh ? (SPRITE_W-1 - rel_x[AX_BITS-1:0]) : rel_x[AX_BITS-1:0].
  - pixel_addr = {frame, rel_y[AY_BITS-1:0], col}.
- Hit:
  - hit = in.hcount >= x_sh && in.hcount < x_sh+SPRITE_W && in.vcount >= y_sh && in.vcount < y_sh+SPRITE_H.
  - Sums use 12-bit width so a sprite near 2047 does not wrap. A partially off-screen sprite is clipped, never wrapped.
- Stage 1 (registered): delayed hcount, vcount, hsync, vsync, hblnk, vblnk, rgb, and hit.
- Stage 2 (registered to out):
  - Timing fields are copied from stage 1.
  - out.rgb = rgb_pixel if stage-1 hit && visible_sh && !hblnk && !vblnk && rgb_pixel != KEY_COLOR; otherwise stage-1 rgb.
- Latency: every out field equals the corresponding in field 2 cycles earlier, except for rgb substitution.
- Simultaneous events: latch and animation step on the same vblnk edge are independent; both take effect. The mirror change applies from the first active line of the new frame.

Decomposition:
- variable_pkg holds the default sprite constants (SPRITE_W/H, KEY_COLOR) and a sprite_cfg_t struct {xpos, ypos, mirror, visible}, for reuse by the cat and dog instances.
- One natural sub-module, sprite_anim_ctrl:
  - owns the vblnk edge detect, the shadow registers, the divider and the frame index;
  - outputs the latched config and frame.
- The draw_sprite top holds the address math and the 2-stage pipeline.

Test Plan:
- Reset mid-frame: assert rst at hcount=300 -> all out fields 0 immediately; after release, no sprite pixels until the first vblnk rise, then timing passes through with latency exactly 2.
- Static draw: xpos=100, ypos=50, ROM pattern = addr[11:0]:
  - in.hcount=100, vcount=50 -> pixel_addr=0, out.rgb=0x000 two cycles later;
  - hcount=163, vcount=113 -> pixel_addr=0xFFF;
  - hcount=164 -> upstream rgb passes.
- Mirror: mirror=1, same position -> at hcount=100 col=63; at hcount=163 col=0.
- Transparency: ROM returns 12'h0F0 inside the sprite -> out.rgb equals upstream rgb; 12'h0F1 -> drawn.
- Mid-frame move: change xpos 100->400 at vcount=200 -> the rest of the frame still draws at 100; the next frame draws at 400.
- Animation: ANIM_DIV=8, anim_en=1 -> frame field of pixel_addr steps 0,1,2,3,0 every 8 vblnk rises; anim_en=0 -> frame holds. With xpos=2040, hit is only for hcount 2040..2047 (no wrap to 0).

Source files
------------

// File: rtl/variable_pkg.sv
// Shared sprite constants, latched-config struct and pixel-bus struct for sprite overlay stages.
package variable_pkg;

  localparam int          DEF_SPRITE_W  = 64;
  localparam int          DEF_SPRITE_H  = 64;
  localparam logic [11:0] DEF_KEY_COLOR = 12'h0F0;

  typedef struct packed {
    logic [10:0] xpos;
    logic [10:0] ypos;
    logic        mirror;
    logic        visible;
  } sprite_cfg_t;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_pix_t;

  // 12-bit compare so a span starting near 2047 is clipped rather than wrapped to 0.
  function automatic logic in_span(input logic [10:0] pos, input logic [10:0] start,
                                   input int len);
    logic [11:0] p;
    logic [11:0] s;
    p = {1'b0, pos};
    s = {1'b0, start};
    return (p >= s) && (p < s + 12'(len));
  endfunction

endpackage

// File: rtl/vga_if.sv
// VGA timing plus colour bundle passed between pixel-pipeline stages.
interface vga_if;
  logic [10:0] vcount;
  logic [10:0] hcount;
  logic        vsync;
  logic        hsync;
  logic        vblnk;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
  modport out (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
endinterface

// File: rtl/sprite_anim_ctrl.sv
// Per-frame shadow config and animation frame counter, both updated on the rising edge of vblnk.
module sprite_anim_ctrl
  import variable_pkg::*;
#(
  parameter int FRAMES   = 4,
  parameter int FR_BITS  = 2,
  parameter int ANIM_DIV = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vblnk_i,
  input  logic               anim_en_i,
  input  sprite_cfg_t        cfg_i,
  output sprite_cfg_t        cfg_o,
  output logic [FR_BITS-1:0] frame_o
);

  logic               vblnk_q;
  logic               latch;
  sprite_cfg_t        cfg_q, cfg_d;
  logic [7:0]         div_q, div_d;
  logic [FR_BITS-1:0] frame_q, frame_d;

  always_comb begin
    latch   = vblnk_i & ~vblnk_q;
    cfg_d   = cfg_q;
    div_d   = div_q;
    frame_d = frame_q;
    if (latch) begin
      cfg_d = cfg_i;
      if (anim_en_i) begin
        if (div_q == 8'(ANIM_DIV - 1)) begin
          div_d   = 8'd0;
          frame_d = (frame_q == FR_BITS'(FRAMES - 1)) ? '0 : frame_q + FR_BITS'(1);
        end else begin
          div_d = div_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vblnk_q <= 1'b0;
      cfg_q   <= '0;
      div_q   <= '0;
      frame_q <= '0;
    end else begin
      vblnk_q <= vblnk_i;
      cfg_q   <= cfg_d;
      div_q   <= div_d;
      frame_q <= frame_d;
    end
  end

  assign cfg_o   = cfg_q;
  assign frame_o = frame_q;

endmodule

// File: rtl/draw_sprite.sv
// Sprite overlay stage: ROM address from raster position, 2-cycle timing pipeline with
// colour-key transparency; ROM data is expected one cycle after pixel_addr.
module draw_sprite
  import variable_pkg::*;
#(
  parameter int          SPRITE_W  = DEF_SPRITE_W,
  parameter int          SPRITE_H  = DEF_SPRITE_H,
  parameter int          AX_BITS   = 6,
  parameter int          AY_BITS   = 6,
  parameter int          FRAMES    = 4,
  parameter int          FR_BITS   = 2,
  parameter int          ANIM_DIV  = 8,
  parameter logic [11:0] KEY_COLOR = DEF_KEY_COLOR
) (
  input  logic                                clk60MHz,
  input  logic                                rst,
  input  logic [10:0]                         xpos,
  input  logic [10:0]                         ypos,
  input  logic                                mirror,
  input  logic                                visible,
  input  logic                                anim_en,
  input  logic [11:0]                         rgb_pixel,
  output logic [FR_BITS+AY_BITS+AX_BITS-1:0]  pixel_addr,
  vga_if.in                                   in,
  vga_if.out                                  out
);

  sprite_cfg_t        cfg_req;
  sprite_cfg_t        cfg_sh;
  logic [FR_BITS-1:0] frame;

  assign cfg_req = '{xpos: xpos, ypos: ypos, mirror: mirror, visible: visible};

  sprite_anim_ctrl #(
    .FRAMES   (FRAMES),
    .FR_BITS  (FR_BITS),
    .ANIM_DIV (ANIM_DIV)
  ) u_anim_ctrl (
    .clk       (clk60MHz),
    .rst       (rst),
    .vblnk_i   (in.vblnk),
    .anim_en_i (anim_en),
    .cfg_i     (cfg_req),
    .cfg_o     (cfg_sh),
    .frame_o   (frame)
  );

  logic [AX_BITS-1:0] rel_x;
  logic [AX_BITS-1:0] col;
  logic [AY_BITS-1:0] rel_y;
  logic               hit;

  // Only the low bits of the offsets address the ROM; the full-width test lives in hit.
  always_comb begin
    rel_x      = in.hcount[AX_BITS-1:0] - cfg_sh.xpos[AX_BITS-1:0];
    rel_y      = in.vcount[AY_BITS-1:0] - cfg_sh.ypos[AY_BITS-1:0];
    col        = cfg_sh.mirror ? (AX_BITS'(SPRITE_W - 1) - rel_x) : rel_x;
    pixel_addr = {frame, rel_y, col};
    hit        = in_span(in.hcount, cfg_sh.xpos, SPRITE_W) &&
                 in_span(in.vcount, cfg_sh.ypos, SPRITE_H);
  end

  vga_pix_t s1_d, s1_q;
  logic     hit_q;
  vga_pix_t out_d, out_q;

  always_comb begin
    s1_d = '{hcount: in.hcount, vcount: in.vcount, hsync: in.hsync, vsync: in.vsync,
             hblnk: in.hblnk, vblnk: in.vblnk, rgb: in.rgb};
    out_d = s1_q;
    if (hit_q && cfg_sh.visible && !s1_q.hblnk && !s1_q.vblnk && (rgb_pixel != KEY_COLOR)) begin
      out_d.rgb = rgb_pixel;
    end
  end

  always_ff @(posedge clk60MHz or posedge rst) begin
    if (rst) begin
      s1_q  <= '0;
      hit_q <= 1'b0;
      out_q <= '0;
    end else begin
      s1_q  <= s1_d;
      hit_q <= hit;
      out_q <= out_d;
    end
  end

  assign out.hcount = out_q.hcount;
  assign out.vcount = out_q.vcount;
  assign out.hsync  = out_q.hsync;
  assign out.vsync  = out_q.vsync;
  assign out.hblnk  = out_q.hblnk;
  assign out.vblnk  = out_q.vblnk;
  assign out.rgb    = out_q.rgb;

endmodule
